seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 132 +++++++++++++
 tb/tb_seq_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential 32-bit radix-2 restoring divider for DIV/DIVU, 33 cycles per operation.
// Handshake: start_i is held until ready_o is seen. annul_i cancels work in flight.
module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] op1_abs, op2_abs;
    logic [32:0] trial;
    logic [31:0] quot, rem;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic. Annul wins over completion in ON.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE:    if (start_i && !annul_i) state_d = (opdata2_i == 32'd0) ? BY_ZERO : ON;
            BY_ZERO: state_d = annul_i ? FREE : END;
            ON: begin
                if (annul_i)              state_d = FREE;
                else if (cnt_q == 6'd32)  state_d = END;
            end
            END:     if (!start_i) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    assign op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    // Partial remainder lives in work_q[63:32]; quotient bits shift in at the bottom.
    assign trial   = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign quot    = neg_quot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    assign rem     = neg_rem_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];

    // Datapath and output next-values
    always_comb begin
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    cnt_d      = '0;
                    work_d     = {32'd0, op1_abs, 1'b0};
                    divisor_d  = op2_abs;
                    neg_quot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d  = signed_div_i & opdata1_i[31];
                end
            end
            BY_ZERO: begin
                cnt_d    = '0;
                work_d   = '0;
                result_d = '0;
                ready_d  = !annul_i;
            end
            ON: begin
                if (annul_i) begin
                    cnt_d    = '0;
                    work_d   = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q == 6'd32) begin
                    cnt_d    = '0;
                    result_d = {rem, quot};
                    ready_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 6'd1;
                    work_d = trial[32] ? {work_q[63:0], 1'b0}
                                       : {trial[31:0], work_q[31:0], 1'b1};
                end
            end
            END: begin
                if (!start_i) begin
                    work_d   = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        result_o = result_q;
        ready_o  = ready_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table with hand-computed results, plus
// annul, reset and handshake corner sequences.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] want;
        logic        zero;
    } vec_t;

    vec_t vecs[12];

    seq_divider dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Called at a negedge. Starts an operation, checks latency and result, then
    // holds start (with a stray annul) in END to confirm the result is held.
    task automatic run_op(input vec_t v);
        int n;
        signed_div_i = v.sgn;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk);                 // E0
        @(negedge clk);                 // after E0
        if (v.zero) begin
            chk("zero_ready_low_after_E0", 64'(ready_o), 64'd0);
            @(negedge clk);
            @(negedge clk);             // after E0+2
            chk("zero_ready_after_E0p2", 64'(ready_o), 64'd1);
        end else begin
            n = 0;
            while (!ready_o && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("latency", 64'(n), 64'd33);
        end
        chk("result", result_o, v.want);
        annul_i = 1'b1;
        repeat (2) @(negedge clk);
        annul_i = 1'b0;
        @(negedge clk);
        chk("end_hold_ready", 64'(ready_o), 64'd1);
        chk("end_hold_result", result_o, v.want);
        $display("op sgn=%0d a=%h b=%h -> result=%h ready=%0d", v.sgn, v.a, v.b, result_o, ready_o);
    endtask

    task automatic release_op();
        start_i = 1'b0;
        @(negedge clk);
        chk("release_ready", 64'(ready_o), 64'd0);
        chk("release_result", result_o, 64'd0);
    endtask

    initial begin
        int   rose;
        vec_t v;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0};
        vecs[3]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 1'b0};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0};
        vecs[5]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 1'b0};
        vecs[6]  = '{1'b1, 32'h12345678,   32'd0,          64'd0,                 1'b1};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd0,          64'd0,                 1'b1};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 1'b0};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0};
        vecs[10] = '{1'b1, 32'd5,          32'd7,          64'h00000005_00000000, 1'b0};
        vecs[11] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 1'b0};

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #2;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i]);
            release_op();
        end

        // start with annul in FREE is ignored; the op begins once annul drops
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("free_annul_ready", 64'(ready_o), 64'd0);
        v = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0};
        run_op(v);
        release_op();

        // annul pulsed at E0+10 during ON
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);                 // E0
        repeat (9) @(posedge clk);      // E0+9
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0; // sampled at E0+10
        @(negedge clk);
        annul_i = 1'b0;
        rose = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || result_o !== 64'd0) rose = 1;
        end
        chk("annul_on_quiet", 64'(rose), 64'd0);
        $display("op annul in ON -> ready stayed low=%0d", rose == 0);
        v = '{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0};
        run_op(v);
        release_op();

        // annul in BY_ZERO
        signed_div_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
        start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);                 // E0
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        rose = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready_o !== 1'b0) rose = 1;
        end
        chk("annul_byzero_quiet", 64'(rose), 64'd0);
        $display("op annul in BY_ZERO -> ready stayed low=%0d", rose == 0);

        // async reset at E0+20 mid-operation
        signed_div_i = 1'b1; opdata1_i = 32'h7FFFFFFF; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);                 // E0
        repeat (20) @(posedge clk);     // E0+20
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_ready", 64'(ready_o), 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        v = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
        run_op(v);

        // async reset while holding a result in END clears outputs before any edge
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_end_ready", 64'(ready_o), 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_ready", 64'(ready_o), 64'd0);
        $display("op reset sequences done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
